// File: rtl/par_to_ser_stream.sv
// par_to_ser_stream: parallel-to-serial converter with an N-lane input word.
// It takes a per-word lane count and emits the valid lanes one per cycle.
// Both ports use a valid/ready handshake. The lane order is selectable, and
// the final beat of each word is marked with last_out.
module par_to_ser_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4,
    parameter int REVERSE    = 0,
    parameter int CW         = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] data_in [0:N-1],
    input  logic [CW-1:0]         count_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  last_out,
    output logic [CW-1:0]         index_out
);

    // Width of a physical lane index (at least one bit so N=1 still works).
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] lanes_r [0:N-1];
    logic [CW-1:0]         count_r;

    logic [CW-1:0]         count_clamp_s;
    logic [CW-1:0]         next_idx_s;
    logic                  accept_s;
    logic                  load_s;
    logic                  beat_done_s;

    // Map an emission-order beat number to the physical lane it presents.
    function automatic logic [IW-1:0] lane_sel(input logic [CW-1:0] beat);
        logic [CW-1:0] lane;
        if (REVERSE != 0) begin
            lane = CW'(N - 1) - beat;
        end else begin
            lane = beat;
        end
        return lane[IW-1:0];
    endfunction

    // A new word can enter when idle, or when the final beat leaves this cycle.
    assign ready_in    = !rst && ((state_r == IDLE) ||
                                  ((state_r == SHIFT) && ready_out && last_out));
    assign accept_s    = valid_in && ready_in;
    assign beat_done_s = valid_out && ready_out;
    // A zero-count word is accepted but never loaded, so it simply vanishes.
    assign load_s      = accept_s && (count_clamp_s != {CW{1'b0}});
    assign next_idx_s  = index_out + CW'(1);

    // Clamp the requested lane count to the number of physical lanes.
    always_comb begin
        count_clamp_s = count_in;
        if (count_in > CW'(N)) begin
            count_clamp_s = CW'(N);
        end else begin
            count_clamp_s = count_in;
        end
    end

    // Control FSM with registered beat outputs; a word loads from IDLE or on its predecessor's last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            index_out <= {CW{1'b0}};
            data_out  <= {DATA_WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            for (int i = 0; i < N; i++) begin
                lanes_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (load_s) begin
            for (int i = 0; i < N; i++) begin
                lanes_r[i] <= data_in[i];
            end
            state_r   <= SHIFT;
            count_r   <= count_clamp_s;
            index_out <= {CW{1'b0}};
            data_out  <= data_in[lane_sel({CW{1'b0}})];
            last_out  <= (count_clamp_s == CW'(1));
            valid_out <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_out <= 1'b0;
                    last_out  <= 1'b0;
                end
                SHIFT: begin
                    if (beat_done_s && !last_out) begin
                        index_out <= next_idx_s;
                        data_out  <= lanes_r[lane_sel(next_idx_s)];
                        last_out  <= (next_idx_s == (count_r - CW'(1)));
                    end else if (beat_done_s) begin
                        state_r   <= IDLE;
                        valid_out <= 1'b0;
                        last_out  <= 1'b0;
                        index_out <= {CW{1'b0}};
                        data_out  <= {DATA_WIDTH{1'b0}};
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    valid_out <= 1'b0;
                    last_out  <= 1'b0;
                    index_out <= {CW{1'b0}};
                    data_out  <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/par_to_ser_stream.md
Name: par_to_ser_stream

Overview:
- Parametrised successor to the team's simple parallel-to-serial converter.
- Accepts an N-lane parallel word with a per-word lane count and emits the valid lanes one per cycle on a serial stream.
- Both sides use a full valid/ready handshake, including output backpressure, selectable lane order and a last-beat marker.
- Sits between wide datapath stages (e.g. systolic array row outputs) and narrow serial consumers.

Parameters:
- DATA_WIDTH, 32, width of each lane and of the serial output.
- N, 4, number of input lanes; N >= 1.
- REVERSE, 0, lane order: 0 emits lane 0 first; 1 emits lane N-1 first.
- CW, $clog2(N+1), width of the count and index fields (derived; do not override).

Ports:
- clk  in  1  clock; all sequential logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  parallel word valid.
- ready_in  out  1  block can accept a word this cycle.
- data_in  in  DATA_WIDTH x [0:N-1]  parallel lanes.
- count_in  in  CW  number of lanes to emit, 0..N; values > N are clamped to N.
- data_out  out  DATA_WIDTH  serial data.
- valid_out  out  1  data_out valid.
- ready_out  in  1  downstream accepts data_out.
- last_out  out  1  current beat is the final lane of its word.
- index_out  out  CW  lane number of the current beat (0-based emission order).

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE, valid_out=0, last_out=0, index_out=0, data_out=0, ready_in=0. Internal lane registers are cleared.
- Reset mid-word discards the remaining lanes. The first cycle after rst falls has ready_in=1 and valid_out=0.
- A word is accepted when valid_in && ready_in. Acceptance latches all N lanes and the clamped count. The word's lanes may then change freely.
- Accepting a word with count k > 0 sets state=SHIFT and index=0. valid_out rises the next cycle; latency is 1 cycle from accept to first beat. There is no combinational data_in->data_out path.
- Beat j (0..k-1) presents lane j (REVERSE=0) or lane N-1-j (REVERSE=1). index_out=j. last_out=1 only when j=k-1.
- A beat completes on valid_out && ready_out. While ready_out=0, data_out, index_out and last_out hold stable and valid_out stays 1.
- ready_in = (state==IDLE) || (state==SHIFT && ready_out && last_out). This gives back-to-back words with no bubble: a word accepted on a last beat produces its first beat in the next cycle.
- If no new word is accepted on the last beat, the block returns to IDLE and valid_out=0 the next cycle.
- count 0: the word is accepted and dropped; no beats are emitted. The state is IDLE the next cycle (also when accepted during a last beat).
- count > N is treated as N.
- Throughput: k cycles per word under continuous ready_out, i.e. 1 beat/cycle sustained.
- N=1: each accepted word with count>=1 produces one beat with last_out=1 and index_out=0. The same handshake rules apply.
- FSM states: IDLE, SHIFT.
  - IDLE->SHIFT on accept with k>0.
  - SHIFT->SHIFT on last-beat accept with k>0, or on non-last beat.
  - SHIFT->IDLE on last beat with no accept, or with an accept of k=0.
- The index counter never exceeds k-1; it is reset to 0 on every new word.

Test Plan:
- N=4, REVERSE=0, ready_out=1, word {A0,A1,A2,A3} with count=4 -> 4 consecutive beats A0..A3, index 0..3, last_out only on A3. valid_out first high 1 cycle after accept.
- Same word with REVERSE=1, count=3 -> beats A3,A2,A1, last on A1. The block is IDLE with valid_out=0 the cycle after.
- Two words presented back-to-back (count 4 then 2), ready_out=1 -> 6 beats with no gap. ready_in=1 exactly on the accept cycle of word 1 and on the last beat of each word.
- Backpressure: ready_out toggles 1,0,0,1,... during a count=4 word -> data_out/index_out/last_out held while ready_out=0. No beat is lost or duplicated; ready_in stays 0 until the last beat completes.
- count=0 word, then count=7 word (clamped to 4) -> first produces no valid_out; second emits 4 beats. Verify with the first word accepted both from IDLE and on a last beat.
- Assert rst for 1 cycle during beat 2 of a count=4 word -> outputs go to 0 immediately (asynchronously), ready_in=1 after release. The next word is emitted cleanly from index 0.
